rvfi_trace_buffer: RTL and testbench
====================================

# rvfi_trace_buffer

Downstream consumer of the core's RVFI retirement port in the formal/trace wrapper. Captures up to NRET retired-instruction records per cycle into a circular buffer and drains them one per cycle over a valid/ready stream to a trace sink or checker. Counts records dropped on overflow and flags gaps in the retirement order sequence.

## Interface

Parameters:
- NRET, 2: retirement ports per cycle
- DEPTH, 16: buffer entries; power of two, at least 2*NRET
- XLEN, 64: PC width
- ILEN, 32: instruction width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- rvfi_valid_i  in  NRET  per-port retire valid
- rvfi_order_i  in  NRET*64  per-port retirement order number
- rvfi_pc_i  in  NRET*XLEN  per-port PC
- rvfi_insn_i  in  NRET*ILEN  per-port instruction word
- rvfi_trap_i  in  NRET  per-port trap flag
- out_valid_o  out  1  head record available
- out_ready_i  in  1  sink accepts head record
- out_rec_o  out  trace_rec_t  head record: {order, pc, insn, trap}
- count_o  out  $clog2(DEPTH+1)  occupied entries
- drop_cnt_o  out  32  records dropped; saturates at 0xFFFF_FFFF
- overflow_o  out  1  sticky; set on any drop
- order_err_o  out  1  sticky; set on an order sequence gap
- stats_clr_i  in  1  clears drop_cnt_o, overflow_o and order_err_o

## Operation

- Push ports in ascending index order. Port k is written only if rvfi_valid_i[k] is set. Valid ports need not be contiguous.
- Free space is DEPTH minus count at the start of the cycle. A pop in the same cycle does not free space for that cycle's pushes.
- If the number of valid ports exceeds the free space:
  - Write the lowest-indexed valid ports that fit.
  - Drop the rest.
  - Add the dropped count to drop_cnt_o, saturating.
  - Set overflow_o.
- Pop happens when out_valid_o and out_ready_i are both high. The read pointer advances by 1.
- Next count = count + pushed - popped.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Order checker:
  - Holds the expected order number, reset value 0.
  - Checks every valid port, including dropped ones, in port order.
  - On a mismatch, set order_err_o, then resynchronise: expected = the offending order + 1.
  - Otherwise expected increments once per valid port.
- stats_clr_i takes effect in the next cycle. If it coincides with a drop, the clear wins: the counter and flags read 0.
- The buffer contents and the expected order number are not affected by stats_clr_i.

## Timing

- Reset values:
  - out_valid_o = 0, count_o = 0, drop_cnt_o = 0, overflow_o = 0, order_err_o = 0.
  - out_rec_o = 0.
  - Read and write pointers = 0; expected order = 0.
- Latency: a record pushed in cycle N is visible on out_valid_o/out_rec_o in cycle N+1 at the earliest.
- out_rec_o is driven from storage at the read pointer. It is stable while out_valid_o is high and out_ready_i is low.
- out_valid_o equals (count_o != 0). There is no combinational path from the rvfi_* inputs to the outputs.
- Throughput: one pop per cycle. Sustained NRET retires per cycle will therefore overflow, by design.
- Full buffer: no pushes are accepted that cycle, even if a pop also occurs.
- Reset asserted mid-operation: all state returns to reset values on the next edge. Buffered records are discarded and not counted as drops.

## Structure

- Package rvfi_trace_pkg holds:
  - trace_rec_t (order[63:0], pc[XLEN-1:0], insn[ILEN-1:0], trap)
  - the drop-counter width constant
- Sub-module rvfi_trace_mem: DEPTH x trace_rec_t register array.
  - NRET write ports, with address and enable per port; one asynchronous read port.
- The top level holds the pointers, the count, push compaction (a prefix count of valid ports giving each port's write offset), the order checker and the statistics.

## Test plan

- Single port, orders 0..4 on port 0, out_ready_i=1 → five records out in order, one cycle after each push; count_o peaks at 1; order_err_o=0.
- Valid ports {0,1} with orders 0,1 every cycle, out_ready_i=0, DEPTH=16 → count_o reaches 16 after 8 cycles. The next cycle drop_cnt_o=2 and overflow_o=1, with count_o held at 16.
- Buffer holds 15 entries and both ports are valid → port 0 is stored, port 1 is dropped, drop_cnt_o increments by 1.
- Port 0 invalid, port 1 valid with order 0 → stored at offset 0; no error.
- Orders 0,1,3 → order_err_o sets in the cycle after order 3 arrives. A following order 4 raises no new error; the record with order 3 is still buffered.
- Wrap-around: push and pop 40 records through DEPTH=16 with random out_ready_i → output order matches input. Assert stats_clr_i while overflow_o=1 → the flags clear the next cycle.

Source files
------------

// File: rtl/rvfi_trace_pkg.sv
// Shared types and constants for the RVFI trace buffer.
package rvfi_trace_pkg;

  localparam int unsigned TRACE_XLEN = 64;
  localparam int unsigned TRACE_ILEN = 32;
  localparam int unsigned DROP_CNT_W = 32;

  typedef struct packed {
    logic [63:0]           order;
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_ILEN-1:0] insn;
    logic                  trap;
  } trace_rec_t;

endpackage

// File: rtl/rvfi_trace_mem.sv
// DEPTH-entry trace record storage: NRET write ports, one asynchronous read port.
module rvfi_trace_mem
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                                 clk,
  input  logic       [NRET-1:0]                we,
  input  logic       [NRET-1:0][$clog2(DEPTH)-1:0] waddr,
  input  trace_rec_t [NRET-1:0]                wdata,
  input  logic       [$clog2(DEPTH)-1:0]       raddr,
  output trace_rec_t                           rdata
);

  trace_rec_t mem [DEPTH];

  // Compacted write addresses are always distinct within a cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRET; k++) begin
      if (we[k]) begin
        mem[waddr[k]] <= wdata[k];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Captures RVFI retirements into a circular buffer, drains one record per cycle,
// counts overflow drops and flags gaps in the retirement order sequence.
module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = TRACE_XLEN,
  parameter int unsigned ILEN  = TRACE_ILEN
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NRET-1:0]                rvfi_valid_i,
  input  logic [NRET*64-1:0]             rvfi_order_i,
  input  logic [NRET*XLEN-1:0]           rvfi_pc_i,
  input  logic [NRET*ILEN-1:0]           rvfi_insn_i,
  input  logic [NRET-1:0]                rvfi_trap_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output trace_rec_t                     out_rec_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic [DROP_CNT_W-1:0]          drop_cnt_o,
  output logic                           overflow_o,
  output logic                           order_err_o,
  input  logic                           stats_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count, free, pushed, dropped;
  logic [NRET-1:0]           we;
  logic [NRET-1:0][AW-1:0]   waddr;
  trace_rec_t [NRET-1:0]     wdata;
  trace_rec_t                rdata;
  logic [63:0]               exp_order, exp_order_next;
  logic                      order_gap;
  logic                      pop;
  logic [DROP_CNT_W-1:0]     drop_cnt;
  logic [DROP_CNT_W:0]       drop_sum;
  logic                      overflow, order_err;

  // Space freed by a same-cycle pop is deliberately not reused.
  assign free = CW'(DEPTH) - count;
  assign pop  = (count != '0) && out_ready_i;

  always_comb begin
    for (int k = 0; k < NRET; k++) begin
      wdata[k].order = rvfi_order_i[k*64 +: 64];
      wdata[k].pc    = rvfi_pc_i[k*XLEN +: XLEN];
      wdata[k].insn  = rvfi_insn_i[k*ILEN +: ILEN];
      wdata[k].trap  = rvfi_trap_i[k];
    end
  end

  // Prefix count of valid ports gives each port's offset from wr_ptr.
  always_comb begin
    pushed  = '0;
    dropped = '0;
    we      = '0;
    waddr   = '0;
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid_i[k]) begin
        if (pushed < free) begin
          we[k]    = 1'b1;
          waddr[k] = wr_ptr + pushed[AW-1:0];
          pushed   = pushed + CW'(1);
        end else begin
          dropped  = dropped + CW'(1);
        end
      end
    end
  end

  // On a mismatch the checker resynchronises to the offending order + 1,
  // which equals expected + 1 when there is no mismatch.
  always_comb begin
    exp_order_next = exp_order;
    order_gap      = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid_i[k]) begin
        if (rvfi_order_i[k*64 +: 64] != exp_order_next) begin
          order_gap = 1'b1;
        end
        exp_order_next = rvfi_order_i[k*64 +: 64] + 64'd1;
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(dropped);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      exp_order <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + pushed[AW-1:0];
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
      end
      count     <= count + pushed - CW'(pop);
      exp_order <= exp_order_next;
      if (stats_clr_i) begin
        drop_cnt  <= '0;
        overflow  <= 1'b0;
        order_err <= 1'b0;
      end else begin
        if (dropped != '0) begin
          drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
          overflow <= 1'b1;
        end
        if (order_gap) begin
          order_err <= 1'b1;
        end
      end
    end
  end

  rvfi_trace_mem #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk_i),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Storage is not reset, so the head is masked to zero while empty.
  assign out_valid_o = (count != '0);
  assign out_rec_o   = out_valid_o ? rdata : '0;
  assign count_o     = count;
  assign drop_cnt_o  = drop_cnt;
  assign overflow_o  = overflow;
  assign order_err_o = order_err;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Self-checking bench for rvfi_trace_buffer: vector table, directed corner cases,
// and a queue scoreboard for the drained record stream.
module tb_rvfi_trace_buffer;
  import rvfi_trace_pkg::*;

  localparam int unsigned NRET  = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NRET-1:0]           rvfi_valid;
  logic [NRET*64-1:0]        rvfi_order;
  logic [NRET*XLEN-1:0]      rvfi_pc;
  logic [NRET*ILEN-1:0]      rvfi_insn;
  logic [NRET-1:0]           rvfi_trap;
  logic                      out_valid;
  logic                      out_ready;
  trace_rec_t                out_rec;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [31:0]               drop_cnt;
  logic                      overflow;
  logic                      order_err;
  logic                      stats_clr;

  always #5 clk = ~clk;

  rvfi_trace_buffer #(
    .NRET  (NRET),
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .ILEN  (ILEN)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rvfi_valid_i (rvfi_valid),
    .rvfi_order_i (rvfi_order),
    .rvfi_pc_i    (rvfi_pc),
    .rvfi_insn_i  (rvfi_insn),
    .rvfi_trap_i  (rvfi_trap),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_rec_o    (out_rec),
    .count_o      (count),
    .drop_cnt_o   (drop_cnt),
    .overflow_o   (overflow),
    .order_err_o  (order_err),
    .stats_clr_i  (stats_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  trace_rec_t  m_q[$];
  logic [63:0] m_exp;
  logic [31:0] m_drop;
  logic        m_ovf;
  logic        m_err;

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] o0;
    logic [63:0] o1;
    logic        ready;
    logic        clr;
    logic [4:0]  e_count;
    logic [31:0] e_drop;
    logic        e_ovf;
    logic        e_err;
  } vec_t;

  vec_t vecs[15];

  function automatic trace_rec_t mk_rec(input logic [63:0] ord);
    trace_rec_t r;
    r.order = ord;
    r.pc    = 64'h8000_0000 + (ord << 2);
    r.insn  = ord[31:0] ^ 32'h0000_0013;
    r.trap  = ord[1];
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                      input logic rdy, input logic clr);
    trace_rec_t  r0, r1;
    logic [63:0] ord;
    logic        popq, gap;
    int          free, drops;
    r0 = mk_rec(o0);
    r1 = mk_rec(o1);
    rvfi_valid = v;
    rvfi_order = {o1, o0};
    rvfi_pc    = {r1.pc, r0.pc};
    rvfi_insn  = {r1.insn, r0.insn};
    rvfi_trap  = {r1.trap, r0.trap};
    out_ready  = rdy;
    stats_clr  = clr;
    chk("out_valid", 256'(out_valid), 256'(m_q.size() != 0));
    popq = rdy && (m_q.size() != 0);
    if (popq) chk("head_rec", 256'(out_rec), 256'(m_q[0]));
    free  = DEPTH - m_q.size();
    drops = 0;
    gap   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (v[k]) begin
        ord = (k == 0) ? o0 : o1;
        if (ord != m_exp) gap = 1'b1;
        m_exp = ord + 64'd1;
        if (free > 0) begin
          m_q.push_back(mk_rec(ord));
          free--;
        end else begin
          drops++;
        end
      end
    end
    if (popq) void'(m_q.pop_front());
    if (clr) begin
      m_drop = '0;
      m_ovf  = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (drops > 0) begin
        m_drop = (m_drop > 32'hFFFF_FFFF - 32'(drops)) ? 32'hFFFF_FFFF : m_drop + 32'(drops);
        m_ovf  = 1'b1;
      end
      if (gap) m_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("count", 256'(count), 256'(m_q.size()));
    chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    chk("order_err", 256'(order_err), 256'(m_err));
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    rvfi_valid = '0;
    out_ready  = 1'b0;
    stats_clr  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_exp  = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_out_rec", 256'(out_rec), 256'(0));
    chk("rst_drop_cnt", 256'(drop_cnt), 256'(0));
    chk("rst_overflow", 256'(overflow), 256'(0));
    chk("rst_order_err", 256'(order_err), 256'(0));
  endtask

  initial begin
    int          sent;
    logic [63:0] next_ord, o0, o1;
    logic [1:0]  v;

    // valid, o0, o1, ready, clr | count, drop, ovf, err
    vecs[0]  = '{2'b01, 64'd0,  64'd0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 64'd1,  64'd0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 64'd2,  64'd0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 64'd3,  64'd0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 64'd4,  64'd0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 64'd0,  64'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 64'd0,  64'd5, 1'b0, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 64'd0,  64'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
    vecs[8]  = '{2'b11, 64'd6,  64'd7, 1'b0, 1'b0, 5'd2, 32'd0, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 64'd9,  64'd0, 1'b0, 1'b0, 5'd3, 32'd0, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 64'd10, 64'd0, 1'b0, 1'b0, 5'd4, 32'd0, 1'b0, 1'b1};
    vecs[11] = '{2'b00, 64'd0,  64'd0, 1'b1, 1'b1, 5'd3, 32'd0, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 64'd0,  64'd0, 1'b1, 1'b0, 5'd2, 32'd0, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 64'd0,  64'd0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 64'd0,  64'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};

    rvfi_order = '0;
    rvfi_pc    = '0;
    rvfi_insn  = '0;
    rvfi_trap  = '0;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].valid, vecs[i].o0, vecs[i].o1, vecs[i].ready, vecs[i].clr);
      chk($sformatf("tbl%0d_count", i), 256'(count), 256'(vecs[i].e_count));
      chk($sformatf("tbl%0d_drop", i), 256'(drop_cnt), 256'(vecs[i].e_drop));
      chk($sformatf("tbl%0d_ovf", i), 256'(overflow), 256'(vecs[i].e_ovf));
      chk($sformatf("tbl%0d_err", i), 256'(order_err), 256'(vecs[i].e_err));
    end

    // Fill to full with two retires per cycle, then overflow.
    do_reset();
    for (int i = 0; i < 8; i++) step(2'b11, 64'(2*i), 64'(2*i+1), 1'b0, 1'b0);
    chk("fill_count16", 256'(count), 256'(16));
    step(2'b11, 64'd16, 64'd17, 1'b0, 1'b0);
    chk("full_count", 256'(count), 256'(16));
    chk("full_drop2", 256'(drop_cnt), 256'(2));
    chk("full_ovf", 256'(overflow), 256'(1));
    step(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("pop_count15", 256'(count), 256'(15));
    step(2'b11, 64'd18, 64'd19, 1'b0, 1'b0);
    chk("partial_count", 256'(count), 256'(16));
    chk("partial_drop3", 256'(drop_cnt), 256'(3));
    // Full with pop: nothing pushed; clear wins over the coincident drop.
    step(2'b11, 64'd20, 64'd21, 1'b1, 1'b1);
    chk("clr_count15", 256'(count), 256'(15));
    chk("clr_drop0", 256'(drop_cnt), 256'(0));
    chk("clr_ovf0", 256'(overflow), 256'(0));
    step(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);

    // Reset with records still buffered.
    do_reset();

    // Wrap-around with random retire pattern and sink backpressure.
    sent     = 0;
    next_ord = '0;
    for (int i = 0; i < 400 && sent < 40; i++) begin
      v  = 2'($urandom_range(0, 3));
      o0 = '0;
      o1 = '0;
      if (v[0]) begin o0 = next_ord; next_ord++; sent++; end
      if (v[1]) begin o1 = next_ord; next_ord++; sent++; end
      step(v, o0, o1, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 40 && m_q.size() != 0; i++) step(2'b00, 64'd0, 64'd0, 1'b1, 1'b0);
    chk("drain_done", 256'(m_q.size()), 256'(0));
    chk("drain_count", 256'(count), 256'(0));
    chk("wrap_no_err", 256'(order_err), 256'(0));

    // Clear flags raised during the random run, if any overflow occurred.
    step(2'b00, 64'd0, 64'd0, 1'b0, 1'b1);
    chk("final_ovf", 256'(overflow), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
